// File: rtl/operand_pkg.sv
// operand_pkg
//   Shared types for the operand load sequencer.
//   ld_state_t : sequencer states (collect A, collect B, present {A,B})
//   ST_ILLEGAL : the one unused 2-bit encoding; the sequencer recovers from it to S_WAIT_A
package operand_pkg;

    typedef enum logic [1:0] {
        S_WAIT_A  = 2'd0,
        S_WAIT_B  = 2'd1,
        S_PRESENT = 2'd2
    } ld_state_t;

    localparam logic [1:0] ST_ILLEGAL = 2'd3;

endpackage

// File: rtl/mod_counter.sv
// mod_counter
//   Free-running modulo-2^CW event counter with a one-cycle wrap pulse.
// Ports
//   clk    in   1   clock, all updates on posedge
//   rst    in   1   synchronous active-low reset
//   inc    in   1   count one event this cycle
//   count  out  CW  events counted, modulo 2^CW
//   wrap   out  1   high for the single cycle after count rolls from 2^CW-1 to 0
module mod_counter
    import operand_pkg::*;
#(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    output logic [CW-1:0] count,
    output logic          wrap
);

    logic [CW-1:0] count_q, count_d;
    logic          wrap_q, wrap_d;

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (inc) begin
            count_d = count_q + 1'b1;
            // The increment that rolls over is the one starting from all-ones.
            wrap_d  = (count_q == {CW{1'b1}});
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count = count_q;
    assign wrap  = wrap_q;

endmodule

// File: rtl/operand_load_ctrl.sv
// operand_load_ctrl
//   Collects operand A then operand B from one shared N-bit bus and presents
//   the assembled word {A,B} to the downstream stage until it is consumed.
//   Consumed pairs are counted modulo 2^CW.
// Ports
//   clk         in   1    clock, all updates on posedge
//   rst         in   1    synchronous active-low reset
//   in_value    in   N    operand value bus (A first, then B)
//   in_valid    in   1    in_value is valid
//   in_ready    out  1    value is accepted this cycle (not while presenting)
//   abort       in   1    drop any partial/presented pair, restart at A
//   out_ab      out  2N   {A,B}, A in the upper half
//   out_valid   out  1    out_ab holds a complete pair
//   out_ready   in   1    downstream consumes out_ab
//   pair_count  out  CW   consumed pairs, modulo 2^CW
//   cnt_wrap    out  1    one-cycle pulse after pair_count wraps to 0
module operand_load_ctrl
    import operand_pkg::*;
#(
    parameter int N  = 8,
    parameter int CW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    in_value,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            abort,
    output logic [2*N-1:0]  out_ab,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [CW-1:0]   pair_count,
    output logic            cnt_wrap
);

    ld_state_t    state_q, state_d;
    logic [N-1:0] a_q, a_d;
    logic [N-1:0] b_q, b_d;
    logic         accept;
    logic         transfer;
    logic         inc;

    assign in_ready  = (state_q != S_PRESENT);
    assign out_valid = (state_q == S_PRESENT);
    assign out_ab    = {a_q, b_q};

    assign accept    = in_valid & in_ready;
    assign transfer  = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        inc     = 1'b0;
        if (abort) begin
            // Abort beats any same-cycle accept or transfer: nothing is
            // stored and nothing is counted; held A/B values are kept.
            state_d = S_WAIT_A;
        end else begin
            case (state_q)
                S_WAIT_A: begin
                    if (accept) begin
                        a_d     = in_value;
                        state_d = S_WAIT_B;
                    end
                end
                S_WAIT_B: begin
                    if (accept) begin
                        b_d     = in_value;
                        state_d = S_PRESENT;
                    end
                end
                S_PRESENT: begin
                    if (transfer) begin
                        state_d = S_WAIT_A;
                        inc     = 1'b1;
                    end
                end
                ld_state_t'(ST_ILLEGAL): begin
                    state_d = S_WAIT_A;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_WAIT_A;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    mod_counter #(
        .CW (CW)
    ) u_pair_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (inc),
        .count (pair_count),
        .wrap  (cnt_wrap)
    );

endmodule
